// File: rtl/bist_signature_analyzer.sv
// BIST response analyzer: compacts CUT output words into a MISR while the controller
// reports running, then checks signature and running-cycle count on finish.
module bist_signature_analyzer #(
    parameter int unsigned      WIDTH  = 16,
    parameter logic [WIDTH-1:0] POLY   = 16'h002D,
    parameter logic [WIDTH-1:0] SEED   = '0,
    parameter int unsigned      NCLOCK = 650
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_i,
    input  logic             running_i,
    input  logic             finish_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic [WIDTH-1:0] golden_i,
    output logic [WIDTH-1:0] signature_o,
    output logic             sig_valid_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             proto_err_o
);

    // One extra bit of headroom so an over-long run can never alias back onto NCLOCK.
    localparam int unsigned   CW        = $clog2(NCLOCK + 1) + 1;
    localparam logic [CW-1:0] CntMax    = {CW{1'b1}};
    localparam logic [CW-1:0] CntTarget = CW'(NCLOCK);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StCompact,
        StCheck,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             err_q, err_d;

    logic             compact;
    logic             check_ok;
    logic [WIDTH-1:0] misr_next;

    assign misr_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_in_i;
    assign check_ok  = (sig_q == golden_i) && (cnt_q == CntTarget) && !err_q;

    // Next-state: init overrides everything; compaction is applied after the decode.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        err_d   = err_q;
        compact = 1'b0;

        if (init_i) begin
            state_d = StArmed;
            sig_d   = SEED;
            cnt_d   = '0;
            valid_d = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StArmed: begin
                    // Finish before any data is a sequence violation.
                    if (finish_i) begin
                        err_d   = 1'b1;
                        state_d = StCheck;
                    end else if (running_i) begin
                        compact = 1'b1;
                        state_d = StCompact;
                    end
                end
                StCompact: begin
                    if (finish_i) begin
                        if (running_i) begin
                            err_d = 1'b1;
                        end
                        state_d = StCheck;
                    end else if (running_i) begin
                        compact = 1'b1;
                    end
                end
                StCheck: begin
                    valid_d = 1'b1;
                    pass_d  = check_ok;
                    fail_d  = !check_ok;
                    state_d = StDone;
                end
                StIdle, StDone: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        if (compact) begin
            sig_d = misr_next;
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CW'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sig_q   <= SEED;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
        end
    end

    assign signature_o = sig_q;
    assign sig_valid_o = valid_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign proto_err_o = err_q;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Bench for bist_signature_analyzer: two instances (NCLOCK=4 and NCLOCK=2) share stimulus
// and are checked every cycle against a behavioural model, plus literal expectations.
module tb_bist_signature_analyzer;

    logic       clk;
    logic       reset;
    logic       init;
    logic       running;
    logic       finish;
    logic [7:0] data_in;
    logic [7:0] golden;

    logic [7:0] sig_a, sig_b;
    logic       valid_a, valid_b, pass_a, pass_b, fail_a, fail_b, err_a, err_b;

    bist_signature_analyzer #(
        .WIDTH (8),
        .POLY  (8'h1D),
        .SEED  (8'h00),
        .NCLOCK(4)
    ) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .init_i     (init),
        .running_i  (running),
        .finish_i   (finish),
        .data_in_i  (data_in),
        .golden_i   (golden),
        .signature_o(sig_a),
        .sig_valid_o(valid_a),
        .pass_o     (pass_a),
        .fail_o     (fail_a),
        .proto_err_o(err_a)
    );

    bist_signature_analyzer #(
        .WIDTH (8),
        .POLY  (8'h1D),
        .SEED  (8'h00),
        .NCLOCK(2)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .init_i     (init),
        .running_i  (running),
        .finish_i   (finish),
        .data_in_i  (data_in),
        .golden_i   (golden),
        .signature_o(sig_b),
        .sig_valid_o(valid_b),
        .pass_o     (pass_b),
        .fail_o     (fail_b),
        .proto_err_o(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase of a run: waiting for init, armed (no data yet), collecting, evaluate due, finished.
    localparam int PhIdle  = 0;
    localparam int PhArmed = 1;
    localparam int PhRun   = 2;
    localparam int PhEval  = 3;
    localparam int PhDone  = 4;

    typedef struct {
        int       phase;
        logic [7:0] sig;
        int       cnt;
        bit       err;
        bit       valid;
        bit       pass;
        bit       fail;
    } model_t;

    model_t m[2];
    int     nclk[2] = '{4, 2};
    int     cmax[2] = '{15, 7};

    // Shift-and-divide step of the MISR in plain integer arithmetic.
    function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] d);
        int v;
        v = (int'(s) * 2) % 256;
        if (int'(s) >= 128) v = v ^ 'h1D;
        v = v ^ int'(d);
        return v[7:0];
    endfunction

    function automatic model_t mstep(input model_t s, input int nc, input int cm, input bit rst,
                                     input bit ini, input bit run, input bit fin,
                                     input logic [7:0] d, input logic [7:0] g);
        model_t n;
        n = s;
        if (rst) begin
            n = '{PhIdle, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        end else if (ini) begin
            n = '{PhArmed, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        end else if (s.phase == PhArmed || s.phase == PhRun) begin
            if (fin) begin
                n.err   = s.err || (s.phase == PhArmed) || run;
                n.phase = PhEval;
            end else if (run) begin
                n.sig   = misr(s.sig, d);
                n.cnt   = (s.cnt + 1 > cm) ? cm : s.cnt + 1;
                n.phase = PhRun;
            end
        end else if (s.phase == PhEval) begin
            n.valid = 1'b1;
            n.pass  = (s.sig == g) && (s.cnt == nc) && !s.err;
            n.fail  = !n.pass;
            n.phase = PhDone;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m[i] = mstep(m[i], nclk[i], cmax[i], reset, init, running, finish, data_in, golden);
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("a_sig", sig_a, m[0].sig);
            check("a_valid", {7'd0, valid_a}, {7'd0, m[0].valid});
            check("a_pass", {7'd0, pass_a}, {7'd0, m[0].pass});
            check("a_fail", {7'd0, fail_a}, {7'd0, m[0].fail});
            check("a_err", {7'd0, err_a}, {7'd0, m[0].err});
            check("b_sig", sig_b, m[1].sig);
            check("b_valid", {7'd0, valid_b}, {7'd0, m[1].valid});
            check("b_pass", {7'd0, pass_b}, {7'd0, m[1].pass});
            check("b_fail", {7'd0, fail_b}, {7'd0, m[1].fail});
            check("b_err", {7'd0, err_b}, {7'd0, m[1].err});
        end
    end

    task automatic step(input bit rst, input bit ini, input bit run, input bit fin,
                        input logic [7:0] d);
        @(negedge clk);
        reset   = rst;
        init    = ini;
        running = run;
        finish  = fin;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        reset   = 1'b1;
        init    = 1'b0;
        running = 1'b0;
        finish  = 1'b0;
        data_in = 8'h00;
        golden  = 8'h00;

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cmp_en = 1'b1;
        check("lit_rst_sig", sig_a, 8'h00);
        check("lit_rst_valid", {7'd0, valid_a}, 8'h00);
        check("lit_rst_flags", {5'd0, pass_a, fail_a, err_a}, 8'h00);

        // Test 1: walking one through the MISR, golden match.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
        check("lit_t1_sig0", sig_a, 8'h01);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("lit_t1_sig1", sig_a, 8'h02);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("lit_t1_sig2", sig_a, 8'h04);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("lit_t1_sig3", sig_a, 8'h08);
        golden = 8'h08;
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("lit_t1_valid_early", {7'd0, valid_a}, 8'h00);
        idle();
        check("lit_t1_valid", {7'd0, valid_a}, 8'h01);
        check("lit_t1_pass", {7'd0, pass_a}, 8'h01);
        check("lit_t1_fail", {7'd0, fail_a}, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
        check("lit_t1_hold", {6'd0, pass_a, valid_a}, 8'h03);

        // Test 2: feedback taps on the NCLOCK=2 instance.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
        check("lit_t2_sig0", sig_b, 8'h80);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("lit_t2_sig1", sig_b, 8'h1D);
        golden = 8'h1D;
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        idle();
        check("lit_t2_pass", {6'd0, pass_b, fail_b}, 8'h02);
        check("lit_t2_a_cnt", {6'd0, pass_a, fail_a}, 8'h01);

        // Test 3: wrong golden.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        golden = 8'h09;
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        idle();
        check("lit_t3_flags", {5'd0, pass_a, fail_a, err_a}, 8'h02);

        // Test 4: one running cycle short.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        golden = 8'h04;
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        idle();
        check("lit_t4_sig", sig_a, 8'h04);
        check("lit_t4_flags", {5'd0, pass_a, fail_a, err_a}, 8'h02);

        // Test 5: running and finish together, then init clears.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        check("lit_t5_nocompact", sig_a, 8'h01);
        idle();
        check("lit_t5_flags", {4'd0, valid_a, pass_a, fail_a, err_a}, 8'h0B);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("lit_t5_clear", {4'd0, valid_a, pass_a, fail_a, err_a}, 8'h00);
        check("lit_t5_sig", sig_a, 8'h00);

        // Test 6: reset mid-run, later strobes ignored.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h03);
        check("lit_t6_rst_sig", sig_a, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        idle();
        idle();
        check("lit_t6_valid", {7'd0, valid_a}, 8'h00);
        check("lit_t6_sig", sig_a, 8'h00);

        // Randomised phase: biased towards runs near NCLOCK with a matching golden half the time.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 199) == 0);
            init    = ($urandom_range(0, 99) < 4);
            running = ($urandom_range(0, 99) < 65);
            finish  = ($urandom_range(0, 99) < 12);
            data_in = 8'($urandom);
            golden  = ($urandom_range(0, 1) == 1) ? m[$urandom_range(0, 1)].sig : 8'($urandom);
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
